issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/issue_sched_pkg.sv | 37 +++
 rtl/issue_pair_chk.sv | 40 ++++
 rtl/issue_sched.sv | 114 +++++++++++
 tb/tb_issue_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// Shared definitions for the dual-issue scheduler: instruction bus width,
// RISC-V opcode constants, scheduler state encoding and the slot payload.
package issue_sched_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

  // One instruction-buffer slot as seen by the scheduler.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              isbranch;
    logic              br_taken;
  } slot_t;

  function automatic logic is_mem(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Instructions that must issue alone.
  function automatic logic is_serial(input logic [OPC_W-1:0] opc);
    return (opc == OPC_SYSTEM) || (opc == OPC_FENCE);
  endfunction

endpackage

// File: rtl/issue_pair_chk.sv
// Combinational pairing-hazard check for the two head instructions.
// Ports: slot0/slot1 - head and next-to-head slot payloads;
//        hazard_c    - 1 when slot1 must not issue together with slot0.
module issue_pair_chk
  import issue_sched_pkg::*;
(
  input  slot_t slot0,
  input  slot_t slot1,
  output logic  hazard_c
);

  logic [OPC_W-1:0] opc0;
  logic [OPC_W-1:0] opc1;
  logic [REG_W-1:0] rd0;
  logic [REG_W-1:0] rs1_1;
  logic [REG_W-1:0] rs2_1;
  logic             writes_rd0;
  logic             raw;
  logic             unused_fields;

  assign opc0  = slot0.inst[6:0];
  assign opc1  = slot1.inst[6:0];
  assign rd0   = slot0.inst[11:7];
  assign rs1_1 = slot1.inst[19:15];
  assign rs2_1 = slot1.inst[24:20];

  // Stores and branches carry no rd even though bits [11:7] are populated.
  assign writes_rd0 = (rd0 != '0) && (opc0 != OPC_STORE) && (opc0 != OPC_BRANCH);
  assign raw        = writes_rd0 && ((rd0 == rs1_1) || (rd0 == rs2_1));

  assign hazard_c = (slot0.isbranch && slot0.br_taken)
                  || (slot0.isbranch && slot1.isbranch)
                  || (is_mem(opc0) && is_mem(opc1))
                  || is_serial(opc0) || is_serial(opc1)
                  || raw;

  assign unused_fields = ^{slot0.inst[31:12], slot1.inst[14:7],
                           slot1.inst[31:25], slot1.br_taken};

endmodule

// File: rtl/issue_sched.sv
// Dual-issue scheduler: decides how many head entries of the instruction
// buffer go to ID each cycle, handles redirect flushes and keeps
// saturating performance counters.
// Ports: clk/rst (async active-high); buf_cnt, slot0_*/slot1_* buffer view;
//        id_ready, redirect control; issue_vld, pop_num, drop_younger
//        (combinational); buf_flush, sched_state (state decode);
//        issue_cnt, dual_cnt (registered counters).
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       buf_cnt,
  input  logic [31:0]      slot0_inst,
  input  logic [31:0]      slot1_inst,
  input  logic             slot0_isbranch,
  input  logic             slot0_br_taken,
  input  logic             slot1_isbranch,
  input  logic             slot1_br_taken,
  input  logic             id_ready,
  input  logic             redirect,
  output logic [1:0]       issue_vld,
  output logic [1:0]       pop_num,
  output logic             drop_younger,
  output logic             buf_flush,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [1:0]       sched_state
);

  localparam int unsigned FCNT_W = 4;
  localparam int unsigned SUM_W  = CNT_W + 1;

  sched_state_t      state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  slot_t             slot0, slot1;
  logic              hazard_c;
  logic              issue0, issue1;
  logic              young_taken;
  logic [SUM_W-1:0]  issue_sum, dual_sum;

  assign slot0 = '{inst: slot0_inst, isbranch: slot0_isbranch, br_taken: slot0_br_taken};
  assign slot1 = '{inst: slot1_inst, isbranch: slot1_isbranch, br_taken: slot1_br_taken};

  issue_pair_chk u_pair_chk (
    .slot0    (slot0),
    .slot1    (slot1),
    .hazard_c (hazard_c)
  );

  // State and flush-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state; redirect wins from every state, including the unused encoding.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (redirect) begin
      state_nxt = ST_FLUSH;
      fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        ST_IDLE:  if (buf_cnt != 3'd0) state_nxt = ST_RUN;
        ST_RUN:   if (buf_cnt == 3'd0) state_nxt = ST_IDLE;
        ST_FLUSH: begin
          if (fcnt == '0) state_nxt = ST_IDLE;
          else            fcnt_nxt  = fcnt - FCNT_W'(1);
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Issue gating; redirect suppresses all issue in its own cycle.
  assign issue0 = (state == ST_RUN) && (buf_cnt >= 3'd1) && id_ready && !redirect;
  assign issue1 = issue0 && (buf_cnt >= 3'd2) && !hazard_c;

  assign issue_vld = {issue1, issue0};
  assign pop_num   = {1'b0, issue0} + {1'b0, issue1};

  // Only the youngest issued instruction's prediction decides the drop.
  assign young_taken  = issue1 ? (slot1_isbranch && slot1_br_taken)
                               : (slot0_isbranch && slot0_br_taken);
  assign drop_younger = issue0 && young_taken && (buf_cnt > {1'b0, pop_num});

  assign buf_flush   = (state == ST_FLUSH);
  assign sched_state = state;

  // Saturating counters: the carry-out of the widened sum selects all-ones.
  assign issue_sum = {1'b0, issue_cnt} + SUM_W'(pop_num);
  assign dual_sum  = {1'b0, dual_cnt} + SUM_W'(issue0 && issue1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      dual_cnt  <= '0;
    end else begin
      issue_cnt <= issue_sum[CNT_W] ? '1 : issue_sum[CNT_W-1:0];
      dual_cnt  <= dual_sum[CNT_W]  ? '1 : dual_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed scenarios plus randomized
// traffic compared against a behavioural scheduler model.
module tb_issue_sched;

  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] ADDX  = 32'h00108133;
  localparam logic [31:0] LW1   = 32'h00012083;
  localparam logic [31:0] LW2   = 32'h00412183;
  localparam logic [31:0] BEQ   = 32'h00000063;

  logic          clk, rst;
  logic [2:0]    buf_cnt;
  logic [31:0]   slot0_inst, slot1_inst;
  logic          slot0_isbranch, slot0_br_taken, slot1_isbranch, slot1_br_taken;
  logic          id_ready, redirect;
  logic [1:0]    issue_vld, pop_num;
  logic          drop_younger, buf_flush;
  logic [CW-1:0] issue_cnt, dual_cnt;
  logic [1:0]    sched_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 running, 2 flushing; flush_left = FLUSH cycles still to show.
  int m_mode, m_flush_left, m_issue, m_dual;

  // Values sampled in the most recent step, for scenario-specific checks.
  logic [1:0] s_vld, s_pop, s_state;
  logic       s_drop, s_flush;

  issue_sched #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .buf_cnt        (buf_cnt),
    .slot0_inst     (slot0_inst),
    .slot1_inst     (slot1_inst),
    .slot0_isbranch (slot0_isbranch),
    .slot0_br_taken (slot0_br_taken),
    .slot1_isbranch (slot1_isbranch),
    .slot1_br_taken (slot1_br_taken),
    .id_ready       (id_ready),
    .redirect       (redirect),
    .issue_vld      (issue_vld),
    .pop_num        (pop_num),
    .drop_younger   (drop_younger),
    .buf_flush      (buf_flush),
    .issue_cnt      (issue_cnt),
    .dual_cnt       (dual_cnt),
    .sched_state    (sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  // Pairing rules evaluated from decoded integer fields.
  function automatic bit ref_hazard(input logic [31:0] a, input logic [31:0] b,
                                    input bit a_br, input bit a_tk, input bit b_br);
    int  oa, ob, rd, r1, r2;
    bit  a_mem, b_mem, a_sys, b_sys, a_wr;
    oa = int'(a & 32'h7f);
    ob = int'(b & 32'h7f);
    rd = int'((a >> 7) & 32'h1f);
    r1 = int'((b >> 15) & 32'h1f);
    r2 = int'((b >> 20) & 32'h1f);
    a_mem = (oa == 3) || (oa == 35);
    b_mem = (ob == 3) || (ob == 35);
    a_sys = (oa == 115) || (oa == 15);
    b_sys = (ob == 115) || (ob == 15);
    a_wr  = (rd != 0) && (oa != 35) && (oa != 99);
    return (a_br && a_tk) || (a_br && b_br) || (a_mem && b_mem) || a_sys || b_sys
           || (a_wr && (rd == r1 || rd == r2));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    case ($urandom_range(6, 0))
      0:       op = 7'h13;
      1:       op = 7'h33;
      2:       op = 7'h03;
      3:       op = 7'h23;
      4:       op = 7'h63;
      5:       op = 7'h73;
      default: op = 7'h0f;
    endcase
    return {7'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
            3'($urandom), 5'($urandom_range(3, 0)), op};
  endfunction

  task automatic model_reset();
    m_mode       = 0;
    m_flush_left = 0;
    m_issue      = 0;
    m_dual       = 0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic step(input int bc, input logic [31:0] i0, input logic [31:0] i1,
                      input bit b0, input bit t0, input bit b1, input bit t1,
                      input bit rdy, input bit rd);
    int e0, e1, ep;
    bit young, edrop;
    buf_cnt        = 3'(bc);
    slot0_inst     = i0;
    slot1_inst     = i1;
    slot0_isbranch = b0;
    slot0_br_taken = t0;
    slot1_isbranch = b1;
    slot1_br_taken = t1;
    id_ready       = rdy;
    redirect       = rd;
    #1;
    e0    = (m_mode == 1 && bc >= 1 && rdy && !rd) ? 1 : 0;
    e1    = (e0 == 1 && bc >= 2 && !ref_hazard(i0, i1, b0, t0, b1)) ? 1 : 0;
    ep    = e0 + e1;
    young = (e1 == 1) ? (b1 && t1) : (b0 && t0);
    edrop = (e0 == 1) && young && (bc > ep);
    s_vld   = issue_vld;
    s_pop   = pop_num;
    s_drop  = drop_younger;
    s_flush = buf_flush;
    s_state = sched_state;
    check("issue_vld",    32'(issue_vld),    32'(e1 * 2 + e0));
    check("pop_num",      32'(pop_num),      32'(ep));
    check("drop_younger", 32'(drop_younger), 32'(edrop));
    check("buf_flush",    32'(buf_flush),    32'(m_mode == 2));
    check("sched_state",  32'(sched_state),  32'(m_mode));
    @(posedge clk);
    m_issue = sat_add(m_issue, ep);
    m_dual  = sat_add(m_dual, e1);
    if (rd) begin
      m_mode       = 2;
      m_flush_left = FC;
    end else if (m_mode == 0) begin
      if (bc != 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bc == 0) m_mode = 0;
    end else begin
      m_flush_left--;
      if (m_flush_left == 0) m_mode = 0;
    end
    @(negedge clk);
    check("issue_cnt", 32'(issue_cnt), 32'(m_issue));
    check("dual_cnt",  32'(dual_cnt),  32'(m_dual));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},   32'(issue_vld),    32'd0);
    check({tag, "_pop"},   32'(pop_num),      32'd0);
    check({tag, "_drop"},  32'(drop_younger), 32'd0);
    check({tag, "_flush"}, 32'(buf_flush),    32'd0);
    check({tag, "_state"}, 32'(sched_state),  32'd0);
    check({tag, "_icnt"},  32'(issue_cnt),    32'd0);
    check({tag, "_dcnt"},  32'(dual_cnt),     32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    buf_cnt        = 3'd2;
    slot0_inst     = ADDI1;
    slot1_inst     = ADDI2;
    slot0_isbranch = 1'b0;
    slot0_br_taken = 1'b0;
    slot1_isbranch = 1'b0;
    slot1_br_taken = 1'b0;
    id_ready       = 1'b1;
    redirect       = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Empty->non-empty costs one bubble, then a clean dual issue.
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("idle_bubble", 32'(s_vld), 32'd0);
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("dual_addi_vld", 32'(s_vld), 32'd3);
    check("dual_addi_pop", 32'(s_pop), 32'd2);
    check("dual_addi_cnt", 32'(dual_cnt), 32'd1);

    step(2, ADDI1, ADDX, 0, 0, 0, 0, 1, 0);
    check("raw_vld", 32'(s_vld), 32'd1);
    check("raw_pop", 32'(s_pop), 32'd1);

    step(2, LW1, LW2, 0, 0, 0, 0, 1, 0);
    check("two_lw_vld", 32'(s_vld), 32'd1);

    step(3, BEQ, ADDI2, 1, 1, 0, 0, 1, 0);
    check("br_taken_vld",  32'(s_vld),  32'd1);
    check("br_taken_drop", 32'(s_drop), 32'd1);

    // Redirect in RUN, then exactly FC flush cycles, IDLE, RUN.
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 1);
    check("redirect_kill", 32'(s_vld), 32'd0);
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("flush_cyc1", 32'(s_flush), 32'd1);
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("flush_cyc2", 32'(s_flush), 32'd1);
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("flush_done", 32'(s_flush), 32'd0);
    check("post_idle",  32'(s_state), 32'd0);
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("run_again", 32'(s_vld), 32'd3);

    for (int i = 0; i < 20; i++) step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 0);
    check("dual_sat",  32'(dual_cnt),  32'(CMAX));
    check("issue_sat", 32'(issue_cnt), 32'(CMAX));

    // Asynchronous reset landing in the middle of a flush.
    step(2, ADDI1, ADDI2, 0, 0, 0, 0, 1, 1);
    check("in_flush", 32'(sched_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_flush");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(4, 0), rand_inst(), rand_inst(),
           $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 0,
           $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 0,
           $urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
